// File: rtl/ps2_multi_param_entry.sv
// PS/2 numeric-entry controller: filters break/extended codes, decodes digit and
// edit keys, and lets the user type a clamped decimal value into one of NUM_CH
// effect channels. The received make code is registered for one cycle before the
// FSM acts on it.
module ps2_multi_param_entry #(
    parameter  int NUM_CH   = 3,
    parameter  int DIGITS   = 3,
    parameter  int VAL_W    = 7,
    parameter  int MAX_VAL  = 100,
    parameter  int INIT_VAL = 50,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int BIN_W    = $clog2(10**DIGITS)
) (
    input  logic                      Clock,
    input  logic                      Reset,
    input  logic [7:0]                ps2_key_data,
    input  logic                      ps2_key_pressed,
    input  logic [NUM_CH-1:0]         ch_enable,
    input  logic [NUM_CH-1:0]         ch_select,
    output logic                      busy,
    output logic [CH_W-1:0]           active_ch,
    output logic [2:0]                digit_count,
    output logic [4*DIGITS-1:0]       entry_bcd,
    output logic [NUM_CH*VAL_W-1:0]   value_out,
    output logic                      update_valid,
    output logic [CH_W-1:0]           update_ch,
    output logic                      aborted
);

    typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_COMMIT, S_ABORT} state_t;

    state_t                    r_state;
    logic                      r_brk_pend;
    logic                      r_key_vld;
    logic [7:0]                r_key_code;
    logic                      r_busy;
    logic [CH_W-1:0]           r_active_ch;
    logic [2:0]                r_digit_count;
    logic [4*DIGITS-1:0]       r_entry_bcd;
    logic [NUM_CH*VAL_W-1:0]   r_value_out;
    logic                      r_update_valid;
    logic [CH_W-1:0]           r_update_ch;
    logic                      r_aborted;

    logic                      w_to_idle;
    logic                      w_is_digit;
    logic [3:0]                w_digit;
    logic                      w_is_enter;
    logic                      w_is_bksp;
    logic                      w_is_esc;
    logic                      w_sel_hit;
    logic [CH_W-1:0]           w_sel_ch;
    logic                      w_en_active;
    logic [4*DIGITS+3:0]       w_shift_in;

    // Weighted sum of the BCD digits, most significant digit first.
    function automatic logic [BIN_W-1:0] bcd_to_bin(input logic [4*DIGITS-1:0] bcd);
        logic [BIN_W-1:0] acc;
        acc = '0;
        for (int k = DIGITS - 1; k >= 0; k--)
            acc = acc * BIN_W'(10) + BIN_W'(bcd[4*k +: 4]);
        return acc;
    endfunction

    // Saturate an entered value to the channel ceiling.
    function automatic logic [VAL_W-1:0] clamp(input logic [BIN_W-1:0] bin);
        if (32'(bin) > MAX_VAL)
            return VAL_W'(MAX_VAL);
        return VAL_W'(bin);
    endfunction

    assign w_to_idle  = (r_state == S_COMMIT) || (r_state == S_ABORT);
    assign w_shift_in = {r_entry_bcd, w_digit};

    // Decode the registered make code into digit / edit actions.
    always_comb begin
        w_is_digit = 1'b0;
        w_digit    = 4'd0;
        w_is_enter = 1'b0;
        w_is_bksp  = 1'b0;
        w_is_esc   = 1'b0;
        case (r_key_code)
            8'h45: begin w_is_digit = 1'b1; w_digit = 4'd0; end
            8'h16: begin w_is_digit = 1'b1; w_digit = 4'd1; end
            8'h1E: begin w_is_digit = 1'b1; w_digit = 4'd2; end
            8'h26: begin w_is_digit = 1'b1; w_digit = 4'd3; end
            8'h25: begin w_is_digit = 1'b1; w_digit = 4'd4; end
            8'h2E: begin w_is_digit = 1'b1; w_digit = 4'd5; end
            8'h36: begin w_is_digit = 1'b1; w_digit = 4'd6; end
            8'h3D: begin w_is_digit = 1'b1; w_digit = 4'd7; end
            8'h3E: begin w_is_digit = 1'b1; w_digit = 4'd8; end
            8'h46: begin w_is_digit = 1'b1; w_digit = 4'd9; end
            8'h5A: w_is_enter = 1'b1;
            8'h66: w_is_bksp  = 1'b1;
            8'h76: w_is_esc   = 1'b1;
            default: ;
        endcase
    end

    // Lowest enabled+selected channel wins; also look up the active channel's enable.
    always_comb begin
        w_sel_hit   = 1'b0;
        w_sel_ch    = '0;
        w_en_active = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_select[i] && ch_enable[i]) begin
                w_sel_hit = 1'b1;
                w_sel_ch  = CH_W'(i);
            end
            if (CH_W'(i) == r_active_ch)
                w_en_active = ch_enable[i];
        end
    end

    // Byte filter: swallow the byte after F0, drop E0, pass make codes on.
    always_ff @(posedge Clock) begin
        if (Reset || w_to_idle) begin
            r_brk_pend <= 1'b0;
            r_key_vld  <= 1'b0;
        end else begin
            r_key_vld <= 1'b0;
            if (ps2_key_pressed) begin
                if (r_brk_pend)
                    r_brk_pend <= 1'b0;
                else if (ps2_key_data == 8'hF0)
                    r_brk_pend <= 1'b1;
                else if (ps2_key_data != 8'hE0)
                    r_key_vld <= 1'b1;
            end
        end
    end

    // Capture the scan code alongside the filter's valid flag.
    always_ff @(posedge Clock) begin
        if (ps2_key_pressed)
            r_key_code <= ps2_key_data;
    end

    // Entry FSM: channel pick, digit editing, commit with clamp, abort.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state        <= S_IDLE;
            r_busy         <= 1'b0;
            r_active_ch    <= '0;
            r_digit_count  <= 3'd0;
            r_entry_bcd    <= '0;
            r_value_out    <= {NUM_CH{VAL_W'(INIT_VAL)}};
            r_update_valid <= 1'b0;
            r_update_ch    <= '0;
            r_aborted      <= 1'b0;
        end else begin
            r_update_valid <= 1'b0;
            r_aborted      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_sel_hit) begin
                        r_state       <= S_ENTRY;
                        r_active_ch   <= w_sel_ch;
                        r_digit_count <= 3'd0;
                        r_entry_bcd   <= '0;
                        r_busy        <= 1'b1;
                    end
                end
                S_ENTRY: begin
                    if (!w_en_active) begin
                        r_state <= S_ABORT;
                    end else if (r_key_vld) begin
                        if (w_is_digit) begin
                            if (r_digit_count < 3'(DIGITS)) begin
                                r_entry_bcd   <= w_shift_in[4*DIGITS-1:0];
                                r_digit_count <= r_digit_count + 3'd1;
                            end
                        end else if (w_is_bksp) begin
                            if (r_digit_count != 3'd0) begin
                                r_entry_bcd   <= r_entry_bcd >> 4;
                                r_digit_count <= r_digit_count - 3'd1;
                            end
                        end else if (w_is_enter) begin
                            r_state <= (r_digit_count != 3'd0) ? S_COMMIT : S_ABORT;
                        end else if (w_is_esc) begin
                            r_state <= S_ABORT;
                        end
                    end
                end
                S_COMMIT: begin
                    r_value_out[int'(r_active_ch)*VAL_W +: VAL_W] <= clamp(bcd_to_bin(r_entry_bcd));
                    r_update_ch    <= r_active_ch;
                    r_update_valid <= 1'b1;
                    r_busy         <= 1'b0;
                    r_state        <= S_IDLE;
                end
                S_ABORT: begin
                    r_aborted <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy         = r_busy;
    assign active_ch    = r_active_ch;
    assign digit_count  = r_digit_count;
    assign entry_bcd    = r_entry_bcd;
    assign value_out    = r_value_out;
    assign update_valid = r_update_valid;
    assign update_ch    = r_update_ch;
    assign aborted      = r_aborted;

endmodule
